// File: rtl/decode_pkg.sv
// Shared opcode and immediate-format constants for the decode stage.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // Immediate format codes
  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd5;
  localparam logic [2:0] IMM_BAD  = 3'd7;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the format from the opcode and
// sign-extends the assembled immediate from instr[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm,
  output logic [2:0]         imm_type
);

  logic [31:0] imm32;

  // Format decode; every format fits in 32 bits before the final extension
  always_comb begin
    imm32    = '0;
    imm_type = IMM_BAD;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          imm_type = IMM_I;
          imm32    = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm32    = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: imm_type = IMM_NONE;
      OPC_OP_32: begin
        if (XLEN == 64) imm_type = IMM_NONE;
      end
      default: ;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer.
// Optional illegal-instruction flagging is built when DECODE_ILLEGAL_CHECK_EN
// is defined; otherwise out_illegal is tied low.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [6:0]         out_opcode,
  output logic [4:0]         out_rd,
  output logic [2:0]         out_funct3,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [6:0]         out_funct7,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_imm_type,
  output logic               out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         imm_type;
    logic               illegal;
  } entry_t;

  entry_t          in_entry, main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_imm_type;
  logic            dec_illegal;
  logic            accept;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr   (in_instr),
    .imm     (dec_imm),
    .imm_type(dec_imm_type)
  );

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic [2:0] f3;
  assign f3 = in_instr[14:12];

  // Flag unknown opcodes and reserved funct3 encodings of memory/control ops
  always_comb begin
    dec_illegal = (dec_imm_type == IMM_BAD) || (in_instr[1:0] != 2'b11);
    case (in_instr[6:0])
      OPC_LOAD:   if (f3 == 3'd7 || ((f3 == 3'd3 || f3 == 3'd6) && XLEN != 64)) dec_illegal = 1'b1;
      OPC_STORE:  if (f3 > 3'd3 || (f3 == 3'd3 && XLEN != 64)) dec_illegal = 1'b1;
      OPC_BRANCH: if (f3 == 3'd2 || f3 == 3'd3) dec_illegal = 1'b1;
      OPC_JALR:   if (f3 != 3'd0) dec_illegal = 1'b1;
      default: ;
    endcase
  end
`else
  assign dec_illegal = 1'b0;
`endif

  assign in_entry = '{pc: in_pc, imm: dec_imm, instr: in_instr, imm_type: dec_imm_type,
                      illegal: dec_illegal};
  assign accept   = in_valid && in_ready_q && !flush;

  // Buffer next-state: refill main from skid first, else from the input; stall into skid
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no input can arrive this cycle
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; in_ready is registered as the complement of the next skid valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.instr[6:0];
  assign out_rd       = main_q.instr[11:7];
  assign out_funct3   = main_q.instr[14:12];
  assign out_rs1      = main_q.instr[19:15];
  assign out_rs2      = main_q.instr[24:20];
  assign out_funct7   = main_q.instr[31:25];
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;

endmodule
